battle_engine: RTL and testbench

Parametrised turn-based battle controller: the successor to the fixed three-a-side battle FSM. It registers per-slot HP for both teams and loads them from the stats ROM one slot per cycle. It orders turns by speed, applies saturating damage, auto-switches fainted monsters, and acts on keyboard presses only (edge-detected). It sits between the overworld controller (`is_battle` / `end_battle`), the combinational stats ROM and damage calculator, the enemy AI, and the battle display.

---
 rtl/battle_pkg.sv | 15 +
 rtl/key_press.sv | 11 +
 rtl/battle_engine.sv | 151 +++++++++++++++
 tb/tb_battle_engine.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/battle_pkg.sv
// battle_pkg: shared keycodes, battle state enum and display state encoding
package battle_pkg;
  localparam logic [7:0] KEY_W = 8'h1A;
  localparam logic [7:0] KEY_A = 8'h04;
  localparam logic [7:0] KEY_S = 8'h16;
  localparam logic [7:0] KEY_D = 8'h07;
  localparam logic [7:0] KEY_ENTER = 8'h28;
  typedef enum logic [3:0] {
    IDLE = 4'd0, LOAD = 4'd1, SELECT = 4'd2, ORDER = 4'd3, HIT1 = 4'd4, MSG1 = 4'd5,
    HIT2 = 4'd6, MSG2 = 4'd7, CHECK = 4'd8, WIN = 4'd9, LOSE = 4'd10
  } state_t;
  function automatic logic [3:0] state_code_of(input state_t s);
    return 4'(s);
  endfunction
endpackage

// File: rtl/key_press.sv
// key_press: registers keycode (Clk, Reset, keycode in) and strobes press once per new nonzero key
module key_press (
  input  logic       Clk,
  input  logic       Reset,
  input  logic [7:0] keycode,
  output logic       press
);
  logic [7:0] keycode_q;
  always_ff @(posedge Clk) keycode_q <= Reset ? '0 : keycode;
  assign press = keycode != '0 && keycode != keycode_q;
endmodule

// File: rtl/battle_engine.sv
// battle_engine: turn-based battle FSM; loads HP from stats ROM, orders turns by speed, applies saturating damage, reports end_battle/result
module battle_engine #(
  parameter int TEAM_SIZE = 3,
  parameter int NUM_MOVES = 4,
  parameter int HP_W = 8,
  parameter int ID_W = 3,
  parameter int MOVE_W = 5,
  localparam int MI_W = $clog2(NUM_MOVES)
) (
  input  logic                          Clk,
  input  logic                          Reset,
  input  logic                          is_battle,
  input  logic [7:0]                    keycode,
  input  logic [TEAM_SIZE*ID_W-1:0]     team,
  input  logic [TEAM_SIZE*ID_W-1:0]     enemy_team,
  output logic [ID_W-1:0]               player_addr,
  output logic [ID_W-1:0]               enemy_addr,
  input  logic [HP_W-1:0]               player_maxhp,
  input  logic [HP_W-1:0]               enemy_maxhp,
  input  logic [7:0]                    player_speed,
  input  logic [7:0]                    enemy_speed,
  input  logic [NUM_MOVES*MOVE_W-1:0]   player_moves,
  input  logic [MOVE_W-1:0]             enemy_move,
  output logic [MOVE_W-1:0]             player_move_id,
  output logic [MOVE_W-1:0]             enemy_move_id,
  output logic                          is_player,
  input  logic [HP_W-1:0]               damage,
  output logic [1:0]                    my_cur,
  output logic [1:0]                    enemy_cur,
  output logic [MI_W-1:0]               move_index,
  output logic [HP_W-1:0]               my_hp,
  output logic [HP_W-1:0]               enemy_hp,
  output logic [3:0]                    state_code,
  output logic                          end_battle,
  output logic                          result
);
  import battle_pkg::*;
  state_t state;
  logic [1:0] k, p_next, e_next;
  logic [HP_W-1:0] php [4];
  logic [HP_W-1:0] ehp [4];
  logic [HP_W-1:0] def_hp, hit_hp;
  logic [MI_W-1:0] mi_next;
  logic press, enter, pfirst, p_all, e_all, atk_alive;
  key_press u_key (.Clk(Clk), .Reset(Reset), .keycode(keycode), .press(press));
  assign enter = press && keycode == KEY_ENTER;
  assign player_addr = team[(state == LOAD ? k : my_cur)*ID_W +: ID_W];
  assign enemy_addr = enemy_team[(state == LOAD ? k : enemy_cur)*ID_W +: ID_W];
  assign my_hp = php[my_cur];
  assign enemy_hp = ehp[enemy_cur];
  assign state_code = state_code_of(state);
  assign atk_alive = is_player ? php[my_cur] != '0 : ehp[enemy_cur] != '0;
  assign def_hp = is_player ? ehp[enemy_cur] : php[my_cur];
  assign hit_hp = def_hp > damage ? def_hp - damage : '0;
  assign mi_next = !press ? move_index :
                   keycode == KEY_W && int'(move_index) >= 2 ? move_index - MI_W'(2) :
                   keycode == KEY_S && int'(move_index) + 2 < NUM_MOVES ? move_index + MI_W'(2) :
                   keycode == KEY_A && move_index[0] ? move_index - MI_W'(1) :
                   keycode == KEY_D && !move_index[0] ? move_index + MI_W'(1) : move_index;
  always_comb begin
    p_all = 1'b1;
    e_all = 1'b1;
    p_next = my_cur;
    e_next = enemy_cur;
    for (int i = TEAM_SIZE - 1; i >= 0; i--) begin
      if (php[2'(i)] != '0) begin
        p_all = 1'b0;
        p_next = 2'(i);
      end
      if (ehp[2'(i)] != '0) begin
        e_all = 1'b0;
        e_next = 2'(i);
      end
    end
  end
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state <= IDLE;
      k <= '0;
      php <= '{default: '0};
      ehp <= '{default: '0};
      my_cur <= '0;
      enemy_cur <= '0;
      move_index <= '0;
      player_move_id <= '0;
      enemy_move_id <= '0;
      pfirst <= 1'b0;
      is_player <= 1'b0;
      end_battle <= 1'b0;
      result <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          k <= '0;
          if (is_battle) state <= LOAD;
        end
        LOAD: begin
          php[k] <= player_maxhp;
          ehp[k] <= enemy_maxhp;
          k <= k + 2'd1;
          if (k == 2'(TEAM_SIZE - 1)) begin
            state <= SELECT;
            my_cur <= '0;
            enemy_cur <= '0;
            move_index <= '0;
          end
        end
        SELECT: begin
          move_index <= mi_next;
          if (enter) state <= ORDER;
        end
        ORDER: begin
          player_move_id <= player_moves[move_index*MOVE_W +: MOVE_W];
          enemy_move_id <= enemy_move;
          pfirst <= player_speed >= enemy_speed;
          is_player <= player_speed >= enemy_speed;
          state <= HIT1;
        end
        HIT1, HIT2: begin
          if (atk_alive && is_player) ehp[enemy_cur] <= hit_hp;
          if (atk_alive && !is_player) php[my_cur] <= hit_hp;
          is_player <= 1'b0;
          state <= state == HIT1 ? MSG1 : MSG2;
        end
        MSG1: begin
          if (enter) begin
            is_player <= !pfirst;
            state <= HIT2;
          end
        end
        MSG2: if (enter) state <= CHECK;
        CHECK: begin
          if (e_all || p_all) begin
            end_battle <= 1'b1;
            result <= e_all;
            state <= e_all ? WIN : LOSE;
          end else begin
            if (php[my_cur] == '0) my_cur <= p_next;
            if (ehp[enemy_cur] == '0) enemy_cur <= e_next;
            state <= SELECT;
          end
        end
        WIN, LOSE: begin
          end_battle <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_battle_engine.sv
// tb_battle_engine: self-checking bench with ROM/damage model, cursor vector table and scripted battle sequences
module tb_battle_engine;
  localparam logic [7:0] KW = 8'h1A, KA = 8'h04, KS = 8'h16, KD = 8'h07, KE = 8'h28;
  logic Clk, Reset, is_battle, is_player, end_battle, result;
  logic [7:0] keycode, player_speed, enemy_speed, player_maxhp, enemy_maxhp, damage, my_hp, enemy_hp;
  logic [8:0] team, enemy_team;
  logic [2:0] player_addr, enemy_addr;
  logic [19:0] player_moves;
  logic [4:0] enemy_move, player_move_id, enemy_move_id;
  logic [1:0] my_cur, enemy_cur, move_index;
  logic [3:0] state_code;
  logic [7:0] pmax [8], emax [8], pspd [8], espd [8];
  logic [7:0] dmg_p, dmg_e;
  int n_cmp = 0, n_bad = 0;
  int exp_q [$];
  int mh, eh;
  typedef struct {logic [7:0] key; int hold; int exp_idx;} cur_vec_t;
  cur_vec_t cv [7];
  battle_engine dut (
    .Clk(Clk), .Reset(Reset), .is_battle(is_battle), .keycode(keycode), .team(team),
    .enemy_team(enemy_team), .player_addr(player_addr), .enemy_addr(enemy_addr),
    .player_maxhp(player_maxhp), .enemy_maxhp(enemy_maxhp), .player_speed(player_speed),
    .enemy_speed(enemy_speed), .player_moves(player_moves), .enemy_move(enemy_move),
    .player_move_id(player_move_id), .enemy_move_id(enemy_move_id), .is_player(is_player),
    .damage(damage), .my_cur(my_cur), .enemy_cur(enemy_cur), .move_index(move_index),
    .my_hp(my_hp), .enemy_hp(enemy_hp), .state_code(state_code), .end_battle(end_battle),
    .result(result)
  );
  assign player_maxhp = pmax[player_addr];
  assign enemy_maxhp = emax[enemy_addr];
  assign player_speed = pspd[player_addr];
  assign enemy_speed = espd[enemy_addr];
  assign damage = is_player ? dmg_p : dmg_e;
  initial Clk = 1'b0;
  always #5 Clk = ~Clk;
  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, required finish before 100000");
    $fatal(1, "timeout");
  end
  task automatic tick();
    @(posedge Clk);
    #1;
  endtask
  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, required %0d", name, act, exp);
    end
  endtask
  task automatic press_key(input logic [7:0] k);
    keycode = k;
    tick();
    keycode = 8'h00;
  endtask
  task automatic load_battle();
    is_battle = 1'b1;
    tick();
    is_battle = 1'b0;
    tick();
    tick();
    check("load_state", state_code, 1);
    tick();
    check("select_state", state_code, 2);
    check("load_my_hp", my_hp, 40);
    check("load_enemy_hp", enemy_hp, 30);
    check("load_my_cur", my_cur, 0);
    check("load_enemy_cur", enemy_cur, 0);
    check("load_move_index", move_index, 0);
  endtask
  task automatic round(input int exp_pf, output int mh1, output int eh1);
    press_key(KE);
    check("order_state", state_code, 3);
    tick();
    check("hit1_is_player", is_player, exp_pf);
    tick();
    mh1 = my_hp;
    eh1 = enemy_hp;
    check("msg1_state", state_code, 5);
    press_key(KE);
    check("hit2_is_player", is_player, 1 - exp_pf);
    tick();
    press_key(KE);
    check("check_state", state_code, 8);
    tick();
  endtask
  initial begin
    cv[0] = '{KD, 1, 1};
    cv[1] = '{KS, 1, 3};
    cv[2] = '{KD, 1, 3};
    cv[3] = '{KW, 1, 1};
    cv[4] = '{KA, 1, 0};
    cv[5] = '{KA, 1, 0};
    cv[6] = '{KS, 10, 2};
    for (int i = 0; i < 8; i++) begin
      pmax[i] = 8'd0; emax[i] = 8'd0; pspd[i] = 8'd50; espd[i] = 8'd50;
    end
    pmax[1] = 8'd40; pmax[2] = 8'd50; pmax[3] = 8'd60;
    emax[4] = 8'd30; emax[5] = 8'd35; emax[6] = 8'd45;
    team = {3'd3, 3'd2, 3'd1};
    enemy_team = {3'd6, 3'd5, 3'd4};
    player_moves = {5'd13, 5'd12, 5'd11, 5'd10};
    enemy_move = 5'd7;
    dmg_p = 8'd25;
    dmg_e = 8'd8;
    Reset = 1'b1;
    is_battle = 1'b0;
    keycode = 8'h00;
    tick();
    tick();
    check("rst_state", state_code, 0);
    check("rst_my_hp", my_hp, 0);
    check("rst_enemy_hp", enemy_hp, 0);
    check("rst_end_battle", end_battle, 0);
    check("rst_result", result, 0);
    check("rst_is_player", is_player, 0);
    check("rst_move_index", move_index, 0);
    check("rst_player_move_id", player_move_id, 0);
    Reset = 1'b0;
    tick();
    load_battle();
    for (int i = 0; i < 7; i++) begin
      exp_q.push_back(cv[i].exp_idx);
      keycode = cv[i].key;
      for (int j = 0; j < cv[i].hold; j++) tick();
      keycode = 8'h00;
      tick();
      check($sformatf("cursor_%0d", i), move_index, exp_q.pop_front());
    end
    round(1, mh, eh);
    check("tie_hit1_enemy_hp", eh, 5);
    check("tie_hit1_my_hp", mh, 40);
    check("tie_my_hp", my_hp, 32);
    check("tie_state", state_code, 2);
    check("tie_move_kept", move_index, 2);
    check("tie_player_move_id", player_move_id, 12);
    check("tie_enemy_move_id", enemy_move_id, 7);
    round(1, mh, eh);
    check("sat_hit1_enemy_hp", eh, 0);
    check("sat_skip_my_hp", my_hp, 32);
    check("sat_enemy_cur", enemy_cur, 1);
    check("sat_enemy_hp", enemy_hp, 35);
    pspd[1] = 8'd40;
    espd[5] = 8'd60;
    round(0, mh, eh);
    check("slow_hit1_my_hp", mh, 24);
    check("slow_hit1_enemy_hp", eh, 35);
    check("slow_enemy_hp", enemy_hp, 10);
    dmg_p = 8'd255;
    round(0, mh, eh);
    check("kill1_enemy_cur", enemy_cur, 2);
    check("kill1_enemy_hp", enemy_hp, 45);
    check("kill1_my_hp", my_hp, 16);
    round(0, mh, eh);
    check("win_state", state_code, 9);
    check("win_end_battle", end_battle, 1);
    check("win_result", result, 1);
    tick();
    check("win_idle", state_code, 0);
    check("win_pulse_end", end_battle, 0);
    load_battle();
    press_key(KE);
    tick();
    tick();
    check("pre_reset_msg1", state_code, 5);
    Reset = 1'b1;
    tick();
    Reset = 1'b0;
    check("mreset_state", state_code, 0);
    check("mreset_my_hp", my_hp, 0);
    check("mreset_enemy_hp", enemy_hp, 0);
    check("mreset_end_battle", end_battle, 0);
    tick();
    check("mreset_end_battle2", end_battle, 0);
    check("mreset_idle2", state_code, 0);
    for (int i = 0; i < 8; i++) begin
      pspd[i] = 8'd50; espd[i] = 8'd50;
    end
    dmg_p = 8'd0;
    dmg_e = 8'd255;
    load_battle();
    round(1, mh, eh);
    check("lose1_my_cur", my_cur, 1);
    check("lose1_my_hp", my_hp, 50);
    check("lose1_enemy_hp", enemy_hp, 30);
    round(1, mh, eh);
    check("lose2_my_cur", my_cur, 2);
    check("lose2_my_hp", my_hp, 60);
    round(1, mh, eh);
    check("lose_state", state_code, 10);
    check("lose_end_battle", end_battle, 1);
    check("lose_result", result, 0);
    tick();
    check("lose_idle", state_code, 0);
    check("lose_pulse_end", end_battle, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
